// File: rtl/ahb_lite_ws_mem_pkg.sv
// rtl/ahb_lite_ws_mem_pkg.sv - AHB-Lite encodings and FSM state type for the wait-state RAM slave
package ahb_lite_ws_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B = 3'd0;
    localparam logic [2:0] HSIZE_H = 3'd1;
    localparam logic [2:0] HSIZE_W = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ws_state_e;

endpackage

// File: rtl/ahb_lite_ws_ram.sv
// rtl/ahb_lite_ws_ram.sv - word RAM with byte-enable synchronous write and asynchronous read
module ahb_lite_ws_ram #(
    parameter int MEM_WORDS = 64,
    parameter int AW        = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_ws_mem.sv
// rtl/ahb_lite_ws_mem.sv - AHB-Lite RAM slave with programmable read/write wait states and ERROR responses
module ahb_lite_ws_mem
    import ahb_lite_ws_mem_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int RD_WAIT   = 2,
    parameter int WR_WAIT   = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] RD_W = 4'(RD_WAIT);
    localparam logic [3:0] WR_W = 4'(WR_WAIT);

    ws_state_e     r_state;
    logic [3:0]    r_cnt;
    logic [AW+1:0] r_addr;
    logic [2:0]    r_size;
    logic          r_write;
    logic          r_hready;
    logic          r_hresp;

    logic          w_accept;
    logic          w_err;
    logic [3:0]    w_wait;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Bursts are treated beat by beat, so SEQ and NONSEQ are equivalent here
    assign w_unused = ^{HBURST, HTRANS[0]};

    assign w_accept = r_hready & HSEL & HTRANS[1];
    assign w_err    = (HADDR >= 32'(4 * MEM_WORDS)) || (HSIZE > HSIZE_W)
                   || (HSIZE == HSIZE_H && HADDR[0])
                   || (HSIZE == HSIZE_W && HADDR[1:0] != 2'b00);
    assign w_wait   = HWRITE ? WR_W : RD_W;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_write  <= 1'b0;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= ST_DATA;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                end
                default: begin
                    if (w_accept) begin
                        r_addr  <= HADDR[AW+1:0];
                        r_size  <= HSIZE;
                        r_write <= HWRITE;
                        if (w_err) begin
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= HRESP_ERROR;
                        end else if (w_wait != 4'd0) begin
                            r_state  <= ST_WAIT;
                            r_cnt    <= w_wait - 4'd1;
                            r_hready <= 1'b0;
                            r_hresp  <= HRESP_OKAY;
                        end else begin
                            r_state  <= ST_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= HRESP_OKAY;
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            HSIZE_B: w_be = 4'b0001 << r_addr[1:0];
            HSIZE_H: w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Commit happens on the edge that closes DATA, so a pipelined read of the same word sees it
    assign w_we = (r_state == ST_DATA) && r_write;

    ahb_lite_ws_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    assign HRDATA = (r_state == ST_DATA && !r_write) ? w_rdata : 32'h0;
    assign HREADY = r_hready;
    assign HRESP  = r_hresp;

endmodule

// File: tb/tb_ahb_lite_ws_mem.sv
// tb/tb_ahb_lite_ws_mem.sv - randomized bench for ahb_lite_ws_mem against a transfer-level memory model
module tb_ahb_lite_ws_mem;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr  [2];
    logic [2:0]  hburst [2];
    logic        hsel   [2];
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];
    logic        hwrite [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [2][64];

    always #5 hclk = ~hclk;

    ahb_lite_ws_mem #(.MEM_WORDS(64), .RD_WAIT(2), .WR_WAIT(1)) dut_ws (
        .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr[0]), .HBURST(hburst[0]),
        .HSEL(hsel[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
        .HWRITE(hwrite[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0])
    );

    ahb_lite_ws_mem #(.MEM_WORDS(64), .RD_WAIT(0), .WR_WAIT(0)) dut_zw (
        .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr[1]), .HBURST(hburst[1]),
        .HSEL(hsel[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
        .HWRITE(hwrite[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        return (a >= 256) || (sz > 2) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    endfunction

    task automatic mdl_write(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int w;
        int lo;
        w  = int'(a / 4);
        lo = int'(a % 4);
        if (sz == 0)      mdl[k][w][8*lo +: 8]  = wd[8*lo +: 8];
        else if (sz == 1) mdl[k][w][8*lo +: 16] = wd[8*lo +: 16];
        else              mdl[k][w]             = wd;
    endtask

    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd);
        bit          err;
        int          exp_w;
        int          waits;
        logic        resp_w;
        logic [31:0] exp_rd;
        err    = is_err(a, sz);
        exp_w  = err ? 1 : (k == 1 ? 0 : (wr ? 1 : 2));
        exp_rd = 32'h0;
        if (!err && !wr) exp_rd = mdl[k][a / 4];
        waits  = 0;
        resp_w = 1'b0;
        @(negedge hclk);
        hsel[k] = 1'b1; htrans[k] = 2'b10; haddr[k] = a; hsize[k] = sz; hwrite[k] = wr;
        hburst[k] = 3'($urandom_range(0, 7));
        @(posedge hclk);
        #1;
        hsel[k] = 1'b0; htrans[k] = 2'b00; hwdata[k] = wd;
        @(negedge hclk);
        while (hready[k] !== 1'b1 && waits < 40) begin
            resp_w |= hresp[k];
            waits++;
            @(negedge hclk);
        end
        rd = hrdata[k];
        check_eq($sformatf("k%0d_waits_%h", k, a), 32'(waits), 32'(exp_w));
        check_eq($sformatf("k%0d_hresp_%h", k, a), {31'b0, hresp[k]}, {31'b0, err});
        check_eq($sformatf("k%0d_wresp_%h", k, a), {31'b0, resp_w}, {31'b0, err});
        check_eq($sformatf("k%0d_hrdata_%h", k, a), rd, exp_rd);
        if (!err && wr) mdl_write(k, a, sz, wd);
    endtask

    logic [31:0] rd, v1, v2, a;
    logic [2:0]  sz;
    int          k;
    bit          wr;

    initial begin
        hresetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            haddr[i] = '0; hburst[i] = '0; hsel[i] = 1'b0; hsize[i] = '0;
            htrans[i] = '0; hwdata[i] = '0; hwrite[i] = 1'b0;
        end
        repeat (2) begin
            @(negedge hclk);
            for (int i = 0; i < 2; i++) begin
                check_eq($sformatf("rst_hready%0d", i), {31'b0, hready[i]}, 32'd1);
                check_eq($sformatf("rst_hresp%0d", i), {31'b0, hresp[i]}, 32'd0);
                check_eq($sformatf("rst_hrdata%0d", i), hrdata[i], 32'd0);
            end
        end
        hresetn = 1'b1;
        @(negedge hclk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("post_hready%0d", i), {31'b0, hready[i]}, 32'd1);
            check_eq($sformatf("post_hresp%0d", i), {31'b0, hresp[i]}, 32'd0);
            check_eq($sformatf("post_hrdata%0d", i), hrdata[i], 32'd0);
        end

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 64; w++)
                xfer(i, 1'b1, 32'(4 * w), 3'd2, $urandom, rd);

        xfer(0, 1'b1, 32'h8, 3'd2, 32'h11223344, rd);
        xfer(0, 1'b0, 32'h8, 3'd2, 32'h0, rd);
        check_eq("t2_read", rd, 32'h11223344);

        xfer(0, 1'b1, 32'h10, 3'd2, 32'h0, rd);
        xfer(0, 1'b1, 32'h11, 3'd0, 32'h0000AA00, rd);
        xfer(0, 1'b1, 32'h12, 3'd1, 32'hBEEF0000, rd);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd);
        check_eq("t3_read", rd, 32'hBEEFAA00);

        v1 = $urandom;
        v2 = $urandom;
        @(negedge hclk);
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h4; hsize[1] = 3'd2; hwrite[1] = 1'b1;
        @(posedge hclk);
        #1;
        haddr[1] = 32'h4; hwrite[1] = 1'b0; hwdata[1] = v1;
        @(negedge hclk);
        check_eq("t4_wr_ready", {31'b0, hready[1]}, 32'd1);
        check_eq("t4_wr_rdata", hrdata[1], 32'h0);
        @(posedge hclk);
        #1;
        haddr[1] = 32'h8; hwrite[1] = 1'b1;
        @(negedge hclk);
        check_eq("t4_rd_ready", {31'b0, hready[1]}, 32'd1);
        check_eq("t4_raw", hrdata[1], v1);
        @(posedge hclk);
        #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = v2;
        @(negedge hclk);
        check_eq("t4_wr2_ready", {31'b0, hready[1]}, 32'd1);
        mdl[1][1] = v1;
        mdl[1][2] = v2;
        xfer(1, 1'b0, 32'h8, 3'd2, 32'h0, rd);
        check_eq("t4_wr2_data", rd, v2);

        xfer(0, 1'b0, 32'h100, 3'd2, 32'h0, rd);
        xfer(0, 1'b0, 32'h2, 3'd2, 32'h0, rd);
        xfer(0, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF, rd);
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd);
        xfer(1, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF, rd);
        xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, rd);

        @(negedge hclk);
        hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'hC; hsize[0] = 3'd2; hwrite[0] = 1'b1;
        @(posedge hclk);
        #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = ~mdl[0][3];
        @(negedge hclk);
        check_eq("t6_in_wait", {31'b0, hready[0]}, 32'd0);
        hresetn = 1'b0;
        #1;
        check_eq("t6_rst_ready", {31'b0, hready[0]}, 32'd1);
        check_eq("t6_rst_resp", {31'b0, hresp[0]}, 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        xfer(0, 1'b0, 32'hC, 3'd2, 32'h0, rd);

        for (int n = 0; n < 400; n++) begin
            k  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if (sz <= 2 && $urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = a + 32'd256 + 32'($urandom_range(0, 1000));
            xfer(k, wr, a, sz, $urandom, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
